instr_fetch_unit: RTL and testbench

- Producer side of the opcode interface. Holds the PC and fetches instruction words from instruction memory over a req/ack handshake.
- Presents each word and its opcode field to the decode/control stage through a valid/ready handshake.
- Consumes the decoded Branch/Jump/jal/JumpReg controls and the ALU zero flag to select the next PC.
- Sits between instruction memory and the control unit/register file in the single-issue MIPS core.

---
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the single-issue MIPS core: owns the PC, fetches words over a
// req/ack memory handshake and hands them to decode over valid/ready, then picks the next PC.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              Branch,
  input  logic              zero,
  input  logic              Jump,
  input  logic              jal,
  input  logic              JumpReg,
  input  logic [ADDR_W-1:0] rs_data,
  output logic              misalign_err
);

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } stateT;

  stateT             state;
  stateT             nextState;
  logic              armed;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcPlus4;
  logic [ADDR_W-1:0] nextPc;
  logic [ADDR_W-1:0] branchOffset;
  logic [ADDR_W-1:0] jumpTarget;
  logic [ADDR_W-1:0] regTarget;
  logic [31:0]       instrReg;
  logic              instrValidReg;
  logic              misalignReg;
  logic              fetchDone;
  logic              accept;
  logic              jumpSel;

  assign fetchDone = imem_req & imem_ack;
  assign accept    = instrValidReg & instr_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nextState = state;
    case (state)
      FETCH: if (fetchDone) nextState = ISSUE;
      ISSUE: if (accept)    nextState = FETCH;
    endcase
  end

  // armed holds off the first request for one cycle after reset, so a stale ack is never taken.
  always_comb begin
    imem_req = 1'b0;
    if (state == FETCH && armed) imem_req = 1'b1;
  end

  assign pcPlus4      = pc + ADDR_W'(4);
  assign branchOffset = {{(ADDR_W-18){instrReg[15]}}, instrReg[15:0], 2'b00};
  assign jumpTarget   = {pcPlus4[ADDR_W-1:ADDR_W-4], instrReg[25:0], 2'b00};
  assign regTarget    = {rs_data[ADDR_W-1:2], 2'b00};

  // jal only adds the link write in the datapath; its target is the plain Jump target.
  assign jumpSel = Jump | (Jump & jal);

  always_comb begin
    nextPc = pcPlus4;
    if (JumpReg)              nextPc = regTarget;
    else if (jumpSel)         nextPc = jumpTarget;
    else if (Branch && zero)  nextPc = pcPlus4 + branchOffset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed         <= 1'b0;
      pc            <= RESET_PC;
      instrReg      <= '0;
      instrValidReg <= 1'b0;
      misalignReg   <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (fetchDone) begin
        instrReg      <= imem_rdata;
        instrValidReg <= 1'b1;
      end else if (accept) begin
        instrValidReg <= 1'b0;
        pc            <= nextPc;
        if (JumpReg && rs_data[1:0] != 2'b00) misalignReg <= 1'b1;
      end
    end
  end

  assign imem_addr    = pc;
  assign instr        = instrReg;
  assign opcode       = instrReg[31:26];
  assign instr_valid  = instrValidReg;
  assign pc_plus4     = pcPlus4;
  assign misalign_err = misalignReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a memory/decode model drives the handshakes and a
// scoreboard of expected fetch addresses and instruction words is compared against the DUT.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_W    = 32'h0000_0000;
  localparam logic [31:0] JR_W     = 32'h0100_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_plus4;
  logic        Branch;
  logic        zero;
  logic        Jump;
  logic        jal;
  logic        JumpReg;
  logic [31:0] rs_data;
  logic        misalign_err;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  typedef struct {
    logic        br;
    logic        zr;
    logic        jmp;
    logic        jl;
    logic        jr;
    logic [31:0] rs;
  } ctrlT;

  typedef struct {
    bit          ok;
    logic [31:0] addr;
    logic [31:0] expAddr;
    logic [31:0] instrV;
    logic [31:0] expInstr;
    logic [5:0]  opc;
    logic [31:0] pcp4;
    logic        valid;
    logic        misalign;
    logic        expMisalign;
    bit          stable;
    bit          held;
    int          reqCycle;
  } obsT;

  logic [31:0] expAddr[$];
  logic [31:0] expInstr[$];
  logic        expMisalign = 1'b0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_plus4     (pc_plus4),
    .Branch       (Branch),
    .zero         (zero),
    .Jump         (Jump),
    .jal          (jal),
    .JumpReg      (JumpReg),
    .rs_data      (rs_data),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  function automatic ctrlT mkCtrl(logic br, logic zr, logic jmp, logic jl, logic jr, logic [31:0] rs);
    ctrlT c;
    c.br = br; c.zr = zr; c.jmp = jmp; c.jl = jl; c.jr = jr; c.rs = rs;
    return c;
  endfunction

  function automatic logic [31:0] modelNextPc(logic [31:0] pc, logic [31:0] w, ctrlT c);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = pc + 32'd4;
    off = {{14{w[15]}}, w[15:0], 2'b00};
    if (c.jr)               return {c.rs[31:2], 2'b00};
    else if (c.jmp)         return {p4[31:28], w[25:0], 2'b00};
    else if (c.br && c.zr)  return p4 + off;
    else                    return p4;
  endfunction

  // Serves one fetch (with ackDelay wait states) and one issue (readyDelay cycles of backpressure),
  // recording what the DUT showed alongside the scoreboard's expectations.
  task automatic runInstr(input logic [31:0] word, input int ackDelay, input int readyDelay,
                          input ctrlT c, output obsT o);
    logic [31:0] snap;
    o.ok = 0; o.addr = 'x; o.expAddr = 32'hFFFF_FFFF; o.instrV = 'x; o.expInstr = 'x;
    o.opc = 'x; o.pcp4 = 'x; o.valid = 1'bx; o.misalign = 1'bx; o.expMisalign = expMisalign;
    o.stable = 1; o.held = 1; o.reqCycle = 0;
    for (int i = 0; i < 100; i++) begin
      if (imem_req === 1'b1) begin
        o.ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!o.ok) return;
    o.reqCycle = cyc;
    o.addr     = imem_addr;
    if (expAddr.size() > 0) o.expAddr = expAddr.pop_front();
    for (int i = 0; i < ackDelay; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== o.addr) o.stable = 0;
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    expInstr.push_back(word);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    o.valid       = instr_valid;
    o.instrV      = instr;
    o.opc         = opcode;
    o.pcp4        = pc_plus4;
    o.misalign    = misalign_err;
    o.expMisalign = expMisalign;
    o.expInstr    = expInstr.pop_front();
    snap = instr;
    for (int i = 0; i < readyDelay; i++) begin
      instr_ready = 1'b0;
      Branch = $urandom; zero = $urandom; Jump = $urandom; JumpReg = $urandom;
      rs_data = 32'h0000_0003;
      @(negedge clk);
      if (instr !== snap || instr_valid !== 1'b1 || imem_req !== 1'b0) o.held = 0;
    end
    Branch = c.br; zero = c.zr; Jump = c.jmp; jal = c.jl; JumpReg = c.jr; rs_data = c.rs;
    expAddr.push_back(modelNextPc(o.expAddr, word, c));
    if (c.jr && c.rs[1:0] != 2'b00) expMisalign = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    Branch = 0; zero = 0; Jump = 0; jal = 0; JumpReg = 0; rs_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 0; imem_rdata = '0; instr_ready = 0;
    Branch = 0; zero = 0; Jump = 0; jal = 0; JumpReg = 0; rs_data = '0;
    repeat (2) @(negedge clk);
    testsRun++; if (imem_req !== 1'b0) begin testsFailed++; $display("FAIL rst_req: got %b want 0", imem_req); end
    testsRun++; if (imem_addr !== RESET_PC) begin testsFailed++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC); end
    testsRun++; if (instr !== 32'h0 || opcode !== 6'h0) begin testsFailed++; $display("FAIL rst_instr: got %h/%h want 0", instr, opcode); end
    testsRun++; if (instr_valid !== 1'b0) begin testsFailed++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    testsRun++; if (pc_plus4 !== RESET_PC + 32'd4) begin testsFailed++; $display("FAIL rst_pcp4: got %h want %h", pc_plus4, RESET_PC + 32'd4); end
    testsRun++; if (misalign_err !== 1'b0) begin testsFailed++; $display("FAIL rst_misalign: got %b want 0", misalign_err); end
    reset = 1'b0;
    @(negedge clk);
    testsRun++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin testsFailed++; $display("FAIL rst_first_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC); end
    expAddr.push_back(RESET_PC);
  endtask

  task automatic test_sequential();
    obsT o;
    int  prevCycle = 0;
    for (int i = 0; i < 4; i++) begin
      runInstr(32'h2008_0000 | 32'(i + 1), 0, 0, mkCtrl(0, 0, 0, 0, 0, 0), o);
      testsRun++; if (o.addr !== o.expAddr) begin testsFailed++; $display("FAIL seq_addr[%0d]: got %h want %h", i, o.addr, o.expAddr); end
      testsRun++; if (o.instrV !== o.expInstr || o.valid !== 1'b1) begin testsFailed++; $display("FAIL seq_instr[%0d]: got %h v=%b want %h v=1", i, o.instrV, o.valid, o.expInstr); end
      testsRun++; if (o.opc !== 6'b001000) begin testsFailed++; $display("FAIL seq_opcode[%0d]: got %b want 001000", i, o.opc); end
      testsRun++; if (o.pcp4 !== o.expAddr + 32'd4) begin testsFailed++; $display("FAIL seq_pcp4[%0d]: got %h want %h", i, o.pcp4, o.expAddr + 32'd4); end
      if (i > 0) begin
        testsRun++; if (o.reqCycle - prevCycle != 2) begin testsFailed++; $display("FAIL seq_rate[%0d]: got %0d cycles want 2", i, o.reqCycle - prevCycle); end
      end
      prevCycle = o.reqCycle;
    end
  endtask

  task automatic test_wait_states();
    obsT o;
    runInstr(32'h2008_0055, 3, 2, mkCtrl(0, 0, 0, 0, 0, 0), o);
    testsRun++; if (o.addr !== o.expAddr) begin testsFailed++; $display("FAIL wait_addr: got %h want %h", o.addr, o.expAddr); end
    testsRun++; if (!o.stable) begin testsFailed++; $display("FAIL wait_req_stable: got unstable want stable"); end
    testsRun++; if (!o.held) begin testsFailed++; $display("FAIL backpressure_hold: got changed want held"); end
    testsRun++; if (o.instrV !== o.expInstr) begin testsFailed++; $display("FAIL wait_instr: got %h want %h", o.instrV, o.expInstr); end
  endtask

  task automatic test_branches();
    obsT o;
    runInstr(JR_W, 0, 0, mkCtrl(0, 0, 0, 0, 1, 32'h0000_0100), o);
    runInstr(32'h1000_FFFE, 0, 0, mkCtrl(1, 1, 0, 0, 0, 0), o);
    testsRun++; if (o.addr !== 32'h0000_0100 || o.addr !== o.expAddr) begin testsFailed++; $display("FAIL br_setup_addr: got %h want %h", o.addr, o.expAddr); end
    runInstr(JR_W, 0, 0, mkCtrl(0, 0, 0, 0, 1, 32'h0000_0100), o);
    testsRun++; if (o.addr !== o.expAddr) begin testsFailed++; $display("FAIL br_taken: got %h want %h", o.addr, o.expAddr); end
    runInstr(32'h1000_FFFE, 0, 0, mkCtrl(1, 0, 0, 0, 0, 0), o);
    runInstr(JR_W, 0, 0, mkCtrl(0, 0, 0, 0, 1, 32'h1000_0040), o);
    testsRun++; if (o.addr !== o.expAddr) begin testsFailed++; $display("FAIL br_not_taken: got %h want %h", o.addr, o.expAddr); end
  endtask

  task automatic test_jumps();
    obsT o;
    runInstr(32'h0800_0010, 0, 0, mkCtrl(0, 0, 1, 0, 0, 0), o);
    testsRun++; if (o.addr !== o.expAddr) begin testsFailed++; $display("FAIL j_setup_addr: got %h want %h", o.addr, o.expAddr); end
    runInstr(32'h0C00_0010, 0, 0, mkCtrl(1, 1, 1, 1, 0, 0), o);
    testsRun++; if (o.addr !== o.expAddr) begin testsFailed++; $display("FAIL j_target: got %h want %h", o.addr, o.expAddr); end
    testsRun++; if (o.pcp4 !== 32'h1000_0044) begin testsFailed++; $display("FAIL jal_link: got %h want 10000044", o.pcp4); end
  endtask

  task automatic test_jump_reg();
    obsT o;
    runInstr(JR_W, 0, 0, mkCtrl(1, 1, 1, 0, 1, 32'h2000_0003), o);
    testsRun++; if (o.addr !== o.expAddr) begin testsFailed++; $display("FAIL jal_target: got %h want %h", o.addr, o.expAddr); end
    testsRun++; if (o.misalign !== 1'b0) begin testsFailed++; $display("FAIL misalign_early: got %b want 0", o.misalign); end
    for (int i = 0; i < 11; i++) begin
      runInstr(NOP_W, 0, 0, mkCtrl(0, 0, 0, 0, 0, 0), o);
      testsRun++; if (o.addr !== o.expAddr) begin testsFailed++; $display("FAIL jr_seq_addr[%0d]: got %h want %h", i, o.addr, o.expAddr); end
      testsRun++; if (o.misalign !== o.expMisalign) begin testsFailed++; $display("FAIL misalign_sticky[%0d]: got %b want %b", i, o.misalign, o.expMisalign); end
    end
  endtask

  task automatic test_wrap();
    obsT o;
    runInstr(JR_W, 0, 0, mkCtrl(0, 0, 0, 0, 1, 32'hFFFF_FFFC), o);
    runInstr(NOP_W, 0, 0, mkCtrl(0, 0, 0, 0, 0, 0), o);
    testsRun++; if (o.addr !== 32'hFFFF_FFFC || o.addr !== o.expAddr) begin testsFailed++; $display("FAIL wrap_top: got %h want %h", o.addr, o.expAddr); end
    testsRun++; if (o.pcp4 !== 32'h0) begin testsFailed++; $display("FAIL wrap_pcp4: got %h want 0", o.pcp4); end
    runInstr(NOP_W, 0, 0, mkCtrl(0, 0, 0, 0, 0, 0), o);
    testsRun++; if (o.addr !== o.expAddr) begin testsFailed++; $display("FAIL wrap_addr: got %h want %h", o.addr, o.expAddr); end
  endtask

  task automatic test_reset_midflight();
    obsT o;
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
    testsRun++; if (imem_req !== 1'b1 || imem_addr !== expAddr[0]) begin testsFailed++; $display("FAIL mid_pending: got req=%b addr=%h want 1/%h", imem_req, imem_addr, expAddr[0]); end
    #2 reset = 1'b1;
    #1;
    testsRun++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin testsFailed++; $display("FAIL mid_rst_req: got req=%b addr=%h want 0/%h", imem_req, imem_addr, RESET_PC); end
    testsRun++; if (instr !== 32'h0 || instr_valid !== 1'b0 || pc_plus4 !== RESET_PC + 32'd4) begin testsFailed++; $display("FAIL mid_rst_out: got %h v=%b p4=%h want 0/0/%h", instr, instr_valid, pc_plus4, RESET_PC + 32'd4); end
    testsRun++; if (misalign_err !== 1'b0) begin testsFailed++; $display("FAIL mid_rst_misalign: got %b want 0", misalign_err); end
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h2008_0BAD;
    @(negedge clk);
    imem_ack   = 1'b0;
    testsRun++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin testsFailed++; $display("FAIL stray_ack: got %h v=%b want 0/0", instr, instr_valid); end
    testsRun++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin testsFailed++; $display("FAIL post_rst_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC); end
    expAddr.delete();
    expInstr.delete();
    expAddr.push_back(RESET_PC);
    expMisalign = 1'b0;
    runInstr(32'h2009_0002, 0, 0, mkCtrl(0, 0, 0, 0, 0, 0), o);
    testsRun++; if (o.addr !== o.expAddr) begin testsFailed++; $display("FAIL post_rst_addr: got %h want %h", o.addr, o.expAddr); end
    testsRun++; if (o.instrV !== o.expInstr) begin testsFailed++; $display("FAIL post_rst_instr: got %h want %h", o.instrV, o.expInstr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_branches();
    test_jumps();
    test_jump_reg();
    test_wrap();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
